eth_link_supervisor: RTL and testbench

- Single-clock sequencer that owns the reset of one 10G transceiver/PHY instance (drives gtwiz reset-all).
- Walks power-good -> QPLL lock -> block lock, then declares link up; retries with backoff on timeout or link loss.
- Sits beside the xcvr/PHY wrapper in the free-running control clock domain.
- Exports status and saturating event counters to the TURF register space.

---
 rtl/eth_link_sup_pkg.sv | 15 +
 rtl/eth_sup_sync.sv | 24 ++
 rtl/eth_link_supervisor.sv | 159 +++++++++++++++
 tb/tb_eth_link_supervisor.sv | 113 +++++++++++
 4 files changed

// File: rtl/eth_link_sup_pkg.sv
// rtl/eth_link_sup_pkg.sv - state encoding shared by the link supervisor files
package eth_link_sup_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_PWR  = 3'd1,
        ST_WAIT_PLL  = 3'd2,
        ST_WAIT_LOCK = 3'd3,
        ST_UP        = 3'd4,
        ST_BACKOFF   = 3'd5
    } state_t;

endpackage

// File: rtl/eth_sup_sync.sv
// rtl/eth_sup_sync.sv - single-bit multi-flop synchronizer with selectable reset value
module eth_sup_sync #(
    parameter int   DEPTH   = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] chain;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            chain <= {DEPTH{RST_VAL}};
        end else begin
            chain <= {chain[DEPTH-2:0], d};
        end
    end

    assign q = chain[DEPTH-1];

endmodule

// File: rtl/eth_link_supervisor.sv
// rtl/eth_link_supervisor.sv - reset sequencer and link monitor for one 10G transceiver/PHY
module eth_link_supervisor
    import eth_link_sup_pkg::*;
#(
    parameter int SYNC_STAGES          = 2,
    parameter int RST_HOLD_CYCLES      = 1000,
    parameter int STEP_TIMEOUT_CYCLES  = 2000000,
    parameter int LINK_DEBOUNCE_CYCLES = 100000,
    parameter int BACKOFF_CYCLES       = 500000,
    parameter int CNT_WIDTH            = 16
) (
    input  logic                 xcvr_ctrl_clk,
    input  logic                 xcvr_ctrl_rst_n,
    input  logic                 enable,
    input  logic                 force_reset,
    input  logic                 clear_counts,
    input  logic                 gtpowergood,
    input  logic                 qpll0lock,
    input  logic                 phy_tx_rst,
    input  logic                 phy_rx_rst,
    input  logic                 phy_rx_block_lock,
    input  logic                 phy_rx_high_ber,
    output logic                 xcvr_rst,
    output logic                 link_up,
    output logic [STATE_W-1:0]   state,
    output logic [CNT_WIDTH-1:0] retry_count,
    output logic [CNT_WIDTH-1:0] timeout_count,
    output logic [CNT_WIDTH-1:0] link_drop_count
);

    localparam int MAX_A  = (RST_HOLD_CYCLES > STEP_TIMEOUT_CYCLES) ? RST_HOLD_CYCLES : STEP_TIMEOUT_CYCLES;
    localparam int MAX_B  = (LINK_DEBOUNCE_CYCLES > BACKOFF_CYCLES) ? LINK_DEBOUNCE_CYCLES : BACKOFF_CYCLES;
    localparam int MAX_P  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int STEP_W = $clog2(MAX_P + 1);
    localparam int LOCK_W = $clog2(STEP_TIMEOUT_CYCLES + 1);

    localparam logic [STEP_W-1:0] HOLD_LAST = STEP_W'(RST_HOLD_CYCLES - 1);
    localparam logic [STEP_W-1:0] TO_LAST   = STEP_W'(STEP_TIMEOUT_CYCLES - 1);
    localparam logic [STEP_W-1:0] DEB_LAST  = STEP_W'(LINK_DEBOUNCE_CYCLES - 1);
    localparam logic [STEP_W-1:0] BO_LAST   = STEP_W'(BACKOFF_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(STEP_TIMEOUT_CYCLES - 1);

    logic pwrgood_s, qpll_s, tx_rst_s, rx_rst_s, block_lock_s, high_ber_s, good_s;

    eth_sup_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_pwr (
        .clk(xcvr_ctrl_clk), .resetn(xcvr_ctrl_rst_n), .d(gtpowergood), .q(pwrgood_s));
    eth_sup_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_pll (
        .clk(xcvr_ctrl_clk), .resetn(xcvr_ctrl_rst_n), .d(qpll0lock), .q(qpll_s));
    eth_sup_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_txr (
        .clk(xcvr_ctrl_clk), .resetn(xcvr_ctrl_rst_n), .d(phy_tx_rst), .q(tx_rst_s));
    eth_sup_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_rxr (
        .clk(xcvr_ctrl_clk), .resetn(xcvr_ctrl_rst_n), .d(phy_rx_rst), .q(rx_rst_s));
    eth_sup_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_blk (
        .clk(xcvr_ctrl_clk), .resetn(xcvr_ctrl_rst_n), .d(phy_rx_block_lock), .q(block_lock_s));
    eth_sup_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ber (
        .clk(xcvr_ctrl_clk), .resetn(xcvr_ctrl_rst_n), .d(phy_rx_high_ber), .q(high_ber_s));

    assign good_s = block_lock_s & ~high_ber_s & ~tx_rst_s & ~rx_rst_s & qpll_s & pwrgood_s;

    state_t              cur_state, nxt_state;
    logic [STEP_W-1:0]   step;
    logic [LOCK_W-1:0]   lock_time;
    logic                inc_retry, inc_timeout, inc_drop;

    always_comb begin
        nxt_state   = cur_state;
        inc_retry   = 1'b0;
        inc_timeout = 1'b0;
        inc_drop    = 1'b0;
        if (!enable) begin
            nxt_state = ST_HOLD;
        end else if (force_reset) begin
            nxt_state = ST_HOLD;
            inc_retry = 1'b1;
        end else begin
            case (cur_state)
                ST_HOLD: if (step == HOLD_LAST) nxt_state = ST_WAIT_PWR;
                ST_WAIT_PWR: begin
                    if (pwrgood_s) begin
                        nxt_state = ST_WAIT_PLL;
                    end else if (step == TO_LAST) begin
                        nxt_state   = ST_HOLD;
                        inc_timeout = 1'b1;
                        inc_retry   = 1'b1;
                    end
                end
                ST_WAIT_PLL: begin
                    if (qpll_s) begin
                        nxt_state = ST_WAIT_LOCK;
                    end else if (step == TO_LAST) begin
                        nxt_state   = ST_HOLD;
                        inc_timeout = 1'b1;
                        inc_retry   = 1'b1;
                    end
                end
                // debounce completion is checked first so it beats a coincident timeout
                ST_WAIT_LOCK: begin
                    if (good_s && step == DEB_LAST) begin
                        nxt_state = ST_UP;
                    end else if (lock_time == LOCK_LAST) begin
                        nxt_state   = ST_BACKOFF;
                        inc_timeout = 1'b1;
                    end
                end
                ST_UP: begin
                    if (!good_s) begin
                        nxt_state = ST_BACKOFF;
                        inc_drop  = 1'b1;
                    end
                end
                ST_BACKOFF: begin
                    if (step == BO_LAST) begin
                        nxt_state = ST_HOLD;
                        inc_retry = 1'b1;
                    end
                end
                default: nxt_state = ST_HOLD;
            endcase
        end
    end

    always_ff @(posedge xcvr_ctrl_clk) begin
        if (!xcvr_ctrl_rst_n) begin
            cur_state <= ST_HOLD;
            xcvr_rst  <= 1'b1;
            link_up   <= 1'b0;
            step      <= '0;
            lock_time <= '0;
        end else begin
            cur_state <= nxt_state;
            xcvr_rst  <= (nxt_state == ST_HOLD);
            link_up   <= (nxt_state == ST_UP);
            if (!enable || force_reset || nxt_state != cur_state) begin
                step      <= '0;
                lock_time <= '0;
            end else if (cur_state == ST_WAIT_LOCK) begin
                step      <= good_s ? step + 1'b1 : '0;
                lock_time <= lock_time + 1'b1;
            end else if (cur_state != ST_UP) begin
                step <= step + 1'b1;
            end
        end
    end

    always_ff @(posedge xcvr_ctrl_clk) begin
        if (!xcvr_ctrl_rst_n || clear_counts) begin
            retry_count     <= '0;
            timeout_count   <= '0;
            link_drop_count <= '0;
        end else begin
            if (inc_retry && retry_count != '1)         retry_count     <= retry_count + 1'b1;
            if (inc_timeout && timeout_count != '1)     timeout_count   <= timeout_count + 1'b1;
            if (inc_drop && link_drop_count != '1)      link_drop_count <= link_drop_count + 1'b1;
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_eth_link_supervisor.sv
// tb/tb_eth_link_supervisor.sv - table-driven checks of the link supervisor sequence
module tb_eth_link_supervisor;

    localparam logic [2:0] S_HOLD = 3'd0, S_PWR = 3'd1, S_PLL = 3'd2;
    localparam logic [2:0] S_LOCK = 3'd3, S_UP = 3'd4, S_BO = 3'd5;

    logic       clk = 1'b0;
    logic       rst_n, en, fr, clr, gp, ql, txr, rxr, bl, ber;
    logic       xcvr_rst, link_up;
    logic [2:0] state;
    logic [3:0] retry_count, timeout_count, link_drop_count;

    eth_link_supervisor #(
        .SYNC_STAGES(2), .RST_HOLD_CYCLES(16), .STEP_TIMEOUT_CYCLES(100),
        .LINK_DEBOUNCE_CYCLES(8), .BACKOFF_CYCLES(20), .CNT_WIDTH(4)
    ) dut (
        .xcvr_ctrl_clk(clk), .xcvr_ctrl_rst_n(rst_n), .enable(en), .force_reset(fr),
        .clear_counts(clr), .gtpowergood(gp), .qpll0lock(ql), .phy_tx_rst(txr),
        .phy_rx_rst(rxr), .phy_rx_block_lock(bl), .phy_rx_high_ber(ber),
        .xcvr_rst(xcvr_rst), .link_up(link_up), .state(state), .retry_count(retry_count),
        .timeout_count(timeout_count), .link_drop_count(link_drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en, gp, ql, bl, ber, fr, clr;
        int         n;
        logic [2:0] st;
        logic [3:0] rc, tc, dc;
    } vec_t;

    vec_t vecs[$];
    logic c_en, c_gp, c_ql, c_bl, c_ber, c_fr, c_clr;
    int   checks = 0;
    int   passed = 0;

    task automatic row(input int n, input logic [2:0] st, input logic [3:0] rc, input logic [3:0] tc,
                       input logic [3:0] dc);
        vec_t v;
        v.en = c_en; v.gp = c_gp; v.ql = c_ql; v.bl = c_bl; v.ber = c_ber; v.fr = c_fr; v.clr = c_clr;
        v.n = n; v.st = st; v.rc = rc; v.tc = tc; v.dc = dc;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; fr = 1'b0; clr = 1'b0;
        gp = 1'b1; ql = 1'b1; txr = 1'b0; rxr = 1'b0; bl = 1'b1; ber = 1'b0;
        c_en = 1'b1; c_gp = 1'b1; c_ql = 1'b1; c_bl = 1'b1; c_ber = 1'b0; c_fr = 1'b0; c_clr = 1'b0;

        // bring-up with all status good
        row(0, S_HOLD, 0, 0, 0); row(15, S_HOLD, 0, 0, 0); row(1, S_PWR, 0, 0, 0);
        row(1, S_PLL, 0, 0, 0);  row(1, S_LOCK, 0, 0, 0);  row(7, S_LOCK, 0, 0, 0);
        row(1, S_UP, 0, 0, 0);
        // one-cycle block_lock drop in UP
        c_bl = 1'b0; row(1, S_UP, 0, 0, 0);
        c_bl = 1'b1; row(1, S_UP, 0, 0, 0); row(1, S_BO, 0, 0, 1); row(19, S_BO, 0, 0, 1);
        row(1, S_HOLD, 1, 0, 1); row(15, S_HOLD, 1, 0, 1); row(1, S_PWR, 1, 0, 1);
        row(1, S_PLL, 1, 0, 1);  row(1, S_LOCK, 1, 0, 1);
        // high_ber glitch restarts the debounce at count 5
        row(3, S_LOCK, 1, 0, 1);
        c_ber = 1'b1; row(1, S_LOCK, 1, 0, 1);
        c_ber = 1'b0; row(9, S_LOCK, 1, 0, 1); row(1, S_UP, 1, 0, 1);
        // force_reset coincident with a visible block_lock drop
        c_bl = 1'b0; row(2, S_UP, 1, 0, 1);
        c_fr = 1'b1; row(1, S_HOLD, 2, 0, 1);
        c_fr = 1'b0; c_bl = 1'b1; c_en = 1'b0; c_gp = 1'b0; row(40, S_HOLD, 2, 0, 1);
        // power-good never arrives: timeout period of 116 cycles
        c_en = 1'b1; row(15, S_HOLD, 2, 0, 1); row(1, S_PWR, 2, 0, 1); row(99, S_PWR, 2, 0, 1);
        row(1, S_HOLD, 3, 1, 1); row(15, S_HOLD, 3, 1, 1); row(1, S_PWR, 3, 1, 1);
        row(99, S_PWR, 3, 1, 1); row(1, S_HOLD, 4, 2, 1);
        // repeated force_reset saturates retry_count
        c_fr = 1'b1;
        for (int i = 1; i <= 14; i++) row(1, S_HOLD, (4 + i > 15) ? 4'd15 : 4'(4 + i), 2, 1);
        c_clr = 1'b1; row(1, S_HOLD, 0, 0, 0);
        c_clr = 1'b0; row(1, S_HOLD, 1, 0, 0);
        // WAIT_LOCK never settles: total-time timeout goes to BACKOFF
        c_fr = 1'b0; c_gp = 1'b1; c_bl = 1'b0;
        row(15, S_HOLD, 1, 0, 0); row(1, S_PWR, 1, 0, 0); row(1, S_PLL, 1, 0, 0);
        row(1, S_LOCK, 1, 0, 0);  row(99, S_LOCK, 1, 0, 0); row(1, S_BO, 1, 1, 0);
        row(19, S_BO, 1, 1, 0);   row(1, S_HOLD, 2, 1, 0);

        repeat (3) tick();
        chk("reset_outputs", {13'd0, state, xcvr_rst, link_up} >> 0, {11'd0, S_HOLD, 1'b1, 1'b0} >> 0);
        chk("reset_counts", {4'd0, retry_count, timeout_count, link_drop_count}, 16'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            en = vecs[i].en; gp = vecs[i].gp; ql = vecs[i].ql; bl = vecs[i].bl;
            ber = vecs[i].ber; fr = vecs[i].fr; clr = vecs[i].clr;
            repeat (vecs[i].n) tick();
            chk($sformatf("row%0d_outputs", i), {11'd0, state, xcvr_rst, link_up},
                {11'd0, vecs[i].st, vecs[i].st == S_HOLD, vecs[i].st == S_UP});
            chk($sformatf("row%0d_counts", i), {4'd0, retry_count, timeout_count, link_drop_count},
                {4'd0, vecs[i].rc, vecs[i].tc, vecs[i].dc});
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
